mux_4_arbiter: RTL and testbench
================================

Name: mux_4_arbiter

Overview:
- Round-robin arbiter that shares one 4:1-multiplexed resource, such as a register-file write port or a memory bus, among four requesters.
- Produces the registered 2-bit select for the 4:1 mux, plus a one-hot grant back to the requesters.
- Enforces a one-cycle dead gap between owners and a maximum hold time, so one requester cannot starve the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (1 <= MAX_HOLD < 2^CNT_W).
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- grant  output  4  one-hot grant, registered; all-zero when no owner.
- select  output  2  binary index of the current or last owner; drives the 4:1 mux select.
- valid  output  1  high when grant is non-zero.
- timeout  output  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- All outputs are registered.
- States:
  - IDLE: no owner.
  - GRANT: owner holds the resource.
  - GAP: one dead cycle after a release.
- Reset (asserted at any time, including mid-grant):
  - Takes effect immediately, without waiting for a clock edge.
  - Values: state=IDLE, grant=0000, select=00, valid=0, timeout=0, hold count=0, priority pointer=0 (req[0] highest).
- Arbitration (from IDLE or at the end of GAP):
  - If req != 0, pick the first set bit searching upward from the pointer, modulo 4.
  - Next edge: state=GRANT, grant=one-hot(winner), select=winner, valid=1, hold count=1.
  - Latency: grant appears one cycle after req is sampled high in IDLE.
- IDLE with req=0000: stay in IDLE.
  - grant=0000, valid=0.
  - select holds its previous value; it is never changed except on a new grant.
- GRANT, normal hold: if req[owner]=1 and hold count < MAX_HOLD, stay in GRANT and increment hold count.
  - Requests from other requesters are ignored while an owner holds the grant.
- GRANT, voluntary release (req[owner]=0):
  - Next edge: state=GAP, grant=0000, valid=0, timeout=0.
  - Pointer = (owner+1) mod 4.
- GRANT, forced release (req[owner]=1 and hold count == MAX_HOLD):
  - Next edge: state=GAP, grant=0000, valid=0, timeout=1 for exactly that cycle.
  - Pointer = (owner+1) mod 4.
  - With MAX_HOLD=8, the owner sees exactly 8 grant cycles.
- GAP: lasts exactly one cycle; grant=0000.
  - At its end, arbitrate as in IDLE; if req=0000, go to IDLE.
  - Minimum turnaround between two owners is therefore one dead cycle.
- A released owner that still requests gets the lowest priority on the next arbitration, because of the pointer advance.
- Simultaneous requests resolve by round-robin order only. No requester is served twice while another requester is continuously requesting.
- grant is never multi-hot, and valid == |grant in every cycle.
- timeout is never asserted outside the GAP cycle that follows a forced release.

Test Plan:
1. Reset and single requester:
   - Stimulus: rst_n=0, then rst_n=1 with req=0000 for 3 cycles, then req=0100.
   - Required: grant=0000, select=00, valid=0 until req rises; one cycle after req=0100 is sampled, grant=0100, select=10, valid=1.
2. Voluntary release and gap:
   - Stimulus: requester 2 is granted, then req drops to 0000.
   - Required: the next cycle has grant=0000 (GAP), then IDLE; select stays 10; timeout stays 0.
3. Round-robin:
   - Stimulus: from reset, req=1111 held; each owner holds 2 cycles, then drops its bit for one cycle and re-raises it.
   - Required: grant sequence 0001, 0010, 0100, 1000, 0001, with one zero-grant GAP cycle between each.
4. Forced release:
   - Stimulus: req=0001 held continuously, MAX_HOLD=8.
   - Required: grant=0001 for exactly 8 cycles; timeout=1 in the following GAP cycle; grant=0001 re-granted after the GAP.
5. Starvation prevention:
   - Stimulus: req=0011 held continuously.
   - Required: grants alternate 0001 (8 cycles), GAP, 0010 (8 cycles), GAP; two timeout pulses per round.
6. Reset mid-grant:
   - Stimulus: rst_n pulled low asynchronously while grant=1000, hold count=5.
   - Required: grant=0000, select=00, valid=0 immediately, without waiting for a clock edge; after release with req=1001, requester 0 wins first.

Source files
------------

// File: rtl/mux_4_arbiter.sv
// Round-robin owner arbitration for a shared 4:1-multiplexed resource.
// Registered one-hot grant plus mux select, one dead cycle between owners, bounded hold time.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner, arbitrate every cycle
// GRANT | owner (select) holds the resource, hold timer running
// GAP   | single dead cycle after a release, then arbitrate as IDLE
module mux_4_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Hold timer counts down from MAX_HOLD-1; terminal count zero marks the last allowed cycle.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       select_q, select_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [7:0]       req_dbl;
    logic [3:0]       req_rot;
    logic [1:0]       win_ofs;
    logic [1:0]       winner;
    logic             owner_req;
    logic             hold_tc;

    // Rotate requests so the pointer position becomes bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr_q +: 4];
        win_ofs = 2'd0;
        if (req_rot[0])      win_ofs = 2'd0;
        else if (req_rot[1]) win_ofs = 2'd1;
        else if (req_rot[2]) win_ofs = 2'd2;
        else if (req_rot[3]) win_ofs = 2'd3;
        winner = ptr_q + win_ofs;
    end

    assign owner_req = req[select_q];
    assign hold_tc   = (hold_q == '0);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        select_d  = select_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        ptr_d     = ptr_q;

        unique case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    state_d  = GRANT;
                    grant_d  = 4'b0001 << winner;
                    select_d = winner;
                    valid_d  = 1'b1;
                    hold_d   = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (!owner_req || hold_tc) begin
                    state_d   = GAP;
                    grant_d   = 4'b0000;
                    valid_d   = 1'b0;
                    timeout_d = owner_req;
                    ptr_d     = select_q + 2'd1;
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            select_q  <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
        end
    end

    assign grant   = grant_q;
    assign select  = select_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_4_arbiter.sv
// Bench for mux_4_arbiter: directed vector table, hand-written corner sequences,
// and random requests checked against a behavioural owner/pointer model.
module tb_mux_4_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] select;
    logic       valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    mux_4_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .grant  (grant),
        .select (select),
        .valid  (valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: who owns the resource, for how long, and where the search starts.
    int m_owner;
    int m_cnt;
    int m_ptr;
    int m_sel;
    bit m_to;

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_sel   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else if (m_cnt == MAX_HOLD) begin
                m_to    = 1'b1;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end else if (r != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (r[idx]) begin
                    m_owner = idx;
                    m_cnt   = 1;
                    m_sel   = idx;
                    break;
                end
            end
        end
    endtask

    function automatic logic [3:0] m_grant();
        if (m_owner < 0) return 4'b0000;
        return 4'(1 << m_owner);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".grant"},   32'(grant),   32'(m_grant()));
        check({tag, ".select"},  32'(select),  32'(m_sel));
        check({tag, ".valid"},   32'(valid),   32'(m_owner >= 0));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
        check({tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
        check({tag, ".valid_or"}, 32'(valid), 32'(|grant));
    endtask

    // Apply req for one clock; return 1ns after the rising edge with the model advanced.
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
        model_step(r);
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rst.grant",   32'(grant),   32'd0);
        check("rst.select",  32'(select),  32'd0);
        check("rst.valid",   32'(valid),   32'd0);
        check("rst.timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic       timeout;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int tos;
        logic [3:0] r;
        logic [3:0] exp_g;
        logic       exp_t;
        int p;

        vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[8]  = '{4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[9]  = '{4'b0111, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[10] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[14] = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{4'b1101, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[16] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[17] = '{4'b1011, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[18] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};

        rst_n = 1'b1;
        req   = 4'b0000;
        model_reset();
        #1;
        rst_n = 1'b0;

        // Directed table: single requester, release/gap, round-robin rotation
        do_reset();
        foreach (vecs[i]) begin
            cycle(vecs[i].req);
            check($sformatf("vec%0d.grant", i),   32'(grant),   32'(vecs[i].grant));
            check($sformatf("vec%0d.select", i),  32'(select),  32'(vecs[i].sel));
            check($sformatf("vec%0d.valid", i),   32'(valid),   32'(vecs[i].valid));
            check($sformatf("vec%0d.timeout", i), 32'(timeout), 32'(vecs[i].timeout));
        end

        // Forced release of a single continuous requester
        do_reset();
        for (int i = 0; i < MAX_HOLD; i++) begin
            cycle(4'b0001);
            check($sformatf("hold%0d.grant", i),   32'(grant),   32'd1);
            check($sformatf("hold%0d.timeout", i), 32'(timeout), 32'd0);
        end
        cycle(4'b0001);
        check("force.grant",   32'(grant),   32'd0);
        check("force.valid",   32'(valid),   32'd0);
        check("force.timeout", 32'(timeout), 32'd1);
        cycle(4'b0001);
        check("regrant.grant",   32'(grant),   32'd1);
        check("regrant.timeout", 32'(timeout), 32'd0);

        // Starvation prevention: two continuous requesters alternate in 8+1 cycle slots
        do_reset();
        tos = 0;
        for (int t = 0; t < 4 * (MAX_HOLD + 1); t++) begin
            cycle(4'b0011);
            p = t % (2 * (MAX_HOLD + 1));
            if (p < MAX_HOLD)            begin exp_g = 4'b0001; exp_t = 1'b0; end
            else if (p == MAX_HOLD)      begin exp_g = 4'b0000; exp_t = 1'b1; end
            else if (p < 2 * MAX_HOLD + 1) begin exp_g = 4'b0010; exp_t = 1'b0; end
            else                         begin exp_g = 4'b0000; exp_t = 1'b1; end
            check($sformatf("starve%0d.grant", t),   32'(grant),   32'(exp_g));
            check($sformatf("starve%0d.timeout", t), 32'(timeout), 32'(exp_t));
            if (timeout) tos++;
        end
        check("starve.timeouts", 32'(tos), 32'd4);

        // Asynchronous reset while requester 3 is at hold count 5
        do_reset();
        for (int i = 0; i < 5; i++) cycle(4'b1000);
        check("midgrant.pre", 32'(grant), 32'(m_grant()));
        #2;
        rst_n = 1'b0;
        #1;
        check("async.grant",  32'(grant),  32'd0);
        check("async.select", 32'(select), 32'd0);
        check("async.valid",  32'(valid),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1001);
        check("post_rst.grant",  32'(grant),  32'b0001);
        check("post_rst.select", 32'(select), 32'd0);

        // Random requests against the model
        do_reset();
        r = 4'b0000;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle(r);
            check_model($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
